// File: rtl/dsm_pkg.sv
// Shared types and constants for the dsm_core front end.
package dsm_pkg;
  localparam int ACC_WIDTH = 32;

  typedef enum logic {SWEEP_SAW = 1'b0, SWEEP_TRI = 1'b1} sweep_mode_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sweep_state_t;
endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter; expire is high in the last held cycle so the
// caller acts on the edge exactly D cycles after the load.
module dwell_timer #(
  parameter int DWELL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [DWELL_WIDTH-1:0] load_val,
  output logic                   expire
);
  logic [DWELL_WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (load)          cnt <= (load_val == '0) ? DWELL_WIDTH'(1) : load_val;
    else if (cnt != '0)     cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == DWELL_WIDTH'(1));
endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear sawtooth/triangle sweep of the NCO phase increment feeding dsm_core.
module nco_sweep_ctrl
  import dsm_pkg::*;
#(
  parameter int ACC_WIDTH   = dsm_pkg::ACC_WIDTH,
  parameter int DWELL_WIDTH = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   aclk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [ACC_WIDTH-1:0]   cfg_start_step,
  input  logic [ACC_WIDTH-1:0]   cfg_stop_step,
  input  logic [ACC_WIDTH-1:0]   cfg_delta,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_mode,
  input  logic [COUNT_WIDTH-1:0] cfg_n_sweeps,
  input  logic                   abort,
  output logic [ACC_WIDTH-1:0]   nco_step,
  output logic                   nco_step_enable,
  output logic                   busy,
  output logic                   sweep_done,
  output logic [COUNT_WIDTH-1:0] sweep_count
);
  sweep_state_t state, state_nxt;
  sweep_mode_t  mode_r;

  logic [ACC_WIDTH-1:0]   start_r, stop_r, delta_r;
  logic [DWELL_WIDTH-1:0] dwell_r;
  logic [COUNT_WIDTH-1:0] n_r;
  logic first, toward_stop, up_init;

  logic [ACC_WIDTH-1:0] tgt, base, lim, step_calc, next_val;
  logic [ACC_WIDTH:0]   sum, diff;
  logic [COUNT_WIDTH:0] cnt_inc;
  logic dir_up, up, at_end, last, expire, step_go, write;

  // toward_stop tracks which half of a triangle we are in; saw keeps it set
  assign tgt     = toward_stop ? stop_r : start_r;
  assign dir_up  = toward_stop ? up_init : !up_init;
  assign at_end  = (nco_step == tgt) || (delta_r == '0);
  assign cnt_inc = {1'b0, sweep_count} + 1'b1;
  assign last    = (n_r != '0) && (cnt_inc == {1'b0, n_r});
  assign step_go = (state == RUN) && !abort && (first || expire);
  assign write   = step_go && (first || !at_end || !last);

  // At an endpoint a triangle restarts from that endpoint heading back
  always_comb begin
    base = nco_step;
    lim  = tgt;
    up   = dir_up;
    if (at_end) begin
      base = tgt;
      lim  = toward_stop ? start_r : stop_r;
      up   = !dir_up;
    end
    sum  = {1'b0, base} + {1'b0, delta_r};
    diff = {1'b0, base} - {1'b0, delta_r};
    if (up) step_calc = (sum[ACC_WIDTH]  || sum[ACC_WIDTH-1:0]  >= lim) ? lim : sum[ACC_WIDTH-1:0];
    else    step_calc = (diff[ACC_WIDTH] || diff[ACC_WIDTH-1:0] <= lim) ? lim : diff[ACC_WIDTH-1:0];
  end

  always_comb begin
    next_val = step_calc;
    if (first)
      next_val = start_r;
    else if (at_end && (mode_r == SWEEP_SAW || delta_r == '0))
      next_val = start_r;
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_valid) state_nxt = RUN;
      RUN:     if (abort) state_nxt = IDLE;
               else if (step_go && !first && at_end && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready  = (state == IDLE);
    busy       = (state == RUN) && !first;
    sweep_done = (state == DONE);
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      start_r         <= '0;
      stop_r          <= '0;
      delta_r         <= '0;
      dwell_r         <= '0;
      n_r             <= '0;
      mode_r          <= SWEEP_SAW;
      first           <= 1'b0;
      toward_stop     <= 1'b1;
      up_init         <= 1'b1;
      nco_step        <= '0;
      nco_step_enable <= 1'b0;
      sweep_count     <= '0;
    end else begin
      nco_step_enable <= write;
      if (state == IDLE && cfg_valid) begin
        start_r     <= cfg_start_step;
        stop_r      <= cfg_stop_step;
        delta_r     <= cfg_delta;
        dwell_r     <= cfg_dwell;
        n_r         <= cfg_n_sweeps;
        mode_r      <= sweep_mode_t'(cfg_mode);
        up_init     <= (cfg_stop_step >= cfg_start_step);
        toward_stop <= 1'b1;
        first       <= 1'b1;
      end
      if (write) nco_step <= next_val;
      if (step_go) begin
        first <= 1'b0;
        if (first)
          sweep_count <= '0;
        else if (at_end) begin
          if (sweep_count != '1) sweep_count <= sweep_count + 1'b1;
          if (mode_r == SWEEP_TRI) toward_stop <= !toward_stop;
        end
      end
    end
  end

  dwell_timer #(.DWELL_WIDTH(DWELL_WIDTH)) u_dwell (
    .clk      (aclk),
    .rst      (rst),
    .load     (write),
    .load_val (dwell_r),
    .expire   (expire)
  );
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Scoreboard bench for nco_sweep_ctrl: expected step writes and completions
// are queued with their cycle offsets and matched as the DUT produces them.
module tb_nco_sweep_ctrl;
  localparam int AW = 32, DW = 16, CW = 8;

  logic          aclk = 1'b0, rst = 1'b1;
  logic          cfg_valid = 1'b0, cfg_ready, cfg_mode = 1'b0, abort = 1'b0;
  logic [AW-1:0] cfg_start_step = '0, cfg_stop_step = '0, cfg_delta = '0, nco_step;
  logic [DW-1:0] cfg_dwell = '0;
  logic [CW-1:0] cfg_n_sweeps = '0, sweep_count;
  logic          nco_step_enable, busy, sweep_done;

  nco_sweep_ctrl #(.ACC_WIDTH(AW), .DWELL_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .aclk(aclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_start_step(cfg_start_step), .cfg_stop_step(cfg_stop_step),
    .cfg_delta(cfg_delta), .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
    .cfg_n_sweeps(cfg_n_sweeps), .abort(abort), .nco_step(nco_step),
    .nco_step_enable(nco_step_enable), .busy(busy), .sweep_done(sweep_done),
    .sweep_count(sweep_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {logic [AW-1:0] val; int cyc; int cnt;} step_t;
  typedef struct {int cyc; int cnt;} done_t;
  step_t sq[$];
  done_t dq[$];
  int  n_cmp = 0, n_err = 0, ecnt = 0, t0 = 0;
  bit  done_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [AW-1:0] v, input int c, input int n);
    step_t e;
    e.val = v; e.cyc = c; e.cnt = n;
    sq.push_back(e);
  endtask

  task automatic push_done(input int c, input int n);
    done_t d;
    d.cyc = c; d.cnt = n;
    dq.push_back(d);
  endtask

  task automatic send(input logic [AW-1:0] s, input logic [AW-1:0] p, input logic [AW-1:0] d,
                      input logic [DW-1:0] dw, input logic m, input logic [CW-1:0] n);
    @(negedge aclk);
    chk("cfg_ready", cfg_ready, 1);
    cfg_start_step = s; cfg_stop_step = p; cfg_delta = d;
    cfg_dwell = dw; cfg_mode = m; cfg_n_sweeps = n; cfg_valid = 1'b1;
    @(posedge aclk); #1;
    cfg_valid = 1'b0;
    t0 = ecnt;
    done_seen = 0;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !done_seen; i++) @(negedge aclk);
    chk("done_seen", done_seen, 1);
    chk("steps_left", sq.size(), 0);
    chk("done_left", dq.size(), 0);
  endtask

  task automatic wait_cyc(input int c);
    while (ecnt - t0 < c) @(negedge aclk);
  endtask

  always @(posedge aclk) ecnt <= ecnt + 1;

  always @(negedge aclk) begin
    step_t e;
    done_t d;
    if (!rst) begin
      if (nco_step_enable) begin
        if (sq.size() == 0) chk("unexp_enable", 1, 0);
        else begin
          e = sq.pop_front();
          chk("step", nco_step, e.val);
          chk("step_cyc", ecnt - t0, e.cyc);
          chk("step_count", sweep_count, e.cnt);
          chk("busy_run", busy, 1);
        end
      end
      if (sweep_done) begin
        done_seen = 1;
        if (dq.size() == 0) chk("unexp_done", 1, 0);
        else begin
          d = dq.pop_front();
          chk("done_cyc", ecnt - t0, d.cyc);
          chk("done_count", sweep_count, d.cnt);
          chk("busy_done", busy, 0);
          chk("en_done", nco_step_enable, 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    chk("rst_step", nco_step, 0);
    chk("rst_en", nco_step_enable, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_count", sweep_count, 0);
    chk("rst_ready", cfg_ready, 1);
    @(negedge aclk); rst = 1'b0;

    // sawtooth up, no clamping needed
    push(32'h400000, 1, 0); push(32'h404000, 4, 0); push(32'h408000, 7, 0);
    push(32'h40C000, 10, 0); push(32'h410000, 13, 0); push_done(16, 1);
    send(32'h400000, 32'h410000, 32'h4000, 3, 1'b0, 1);
    wait_done(40);

    // clamp on up
    push(0, 1, 0); push(4, 2, 0); push(8, 3, 0); push(10, 4, 0); push_done(5, 1);
    send(0, 10, 4, 1, 1'b0, 1);
    wait_done(20);

    // down sweep
    push(100, 1, 0); push(95, 2, 0); push(90, 3, 0); push_done(4, 1);
    send(100, 90, 5, 1, 1'b0, 1);
    wait_done(20);

    // no wrap at top of range
    push(32'hFFFFFFF0, 1, 0); push(32'hFFFFFFFF, 2, 0); push_done(3, 1);
    send(32'hFFFFFFF0, 32'hFFFFFFFF, 32'h10, 1, 1'b0, 1);
    wait_done(20);

    // triangle, two halves
    push(0, 1, 0); push(4, 2, 0); push(8, 3, 0); push(4, 4, 1); push(0, 5, 1); push_done(6, 2);
    send(0, 8, 4, 1, 1'b1, 2);
    wait_done(20);

    // endless sawtooth, aborted mid-run
    push(0, 1, 0); push(2, 3, 0); push(4, 5, 0); push(0, 7, 1); push(2, 9, 1);
    send(0, 4, 2, 2, 1'b0, 0);
    wait_cyc(9);
    abort = 1'b1;
    @(posedge aclk); #1; abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_step", nco_step, 2);
    chk("abort_ready", cfg_ready, 1);
    chk("abort_left", sq.size(), 0);

    // dwell 0 acts as 1
    push(0, 1, 0); push(1, 2, 0); push(2, 3, 0); push_done(4, 1);
    send(0, 2, 1, 0, 1'b0, 1);
    wait_done(20);

    // delta 0: single value per sweep
    push(5, 1, 0); push(5, 3, 1); push(5, 5, 2); push_done(7, 3);
    send(5, 9, 0, 2, 1'b0, 3);
    wait_done(20);

    // sweep_count saturation with start == stop
    for (int i = 0; i < 300; i++) push(32'h55, i + 1, (i > 255) ? 255 : i);
    send(32'h55, 32'h55, 1, 1, 1'b0, 0);
    wait_cyc(300);
    abort = 1'b1;
    @(posedge aclk); #1; abort = 1'b0;
    chk("sat_count", sweep_count, 255);
    chk("sat_left", sq.size(), 0);
    chk("sat_busy", busy, 0);

    // async reset mid-dwell
    push(32'h100, 1, 0);
    send(32'h100, 32'h200, 1, 100, 1'b0, 1);
    wait_cyc(5);
    #2 rst = 1'b1;
    #1;
    chk("arst_step", nco_step, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", cfg_ready, 1);
    chk("arst_en", nco_step_enable, 0);
    chk("arst_count", sweep_count, 0);
    chk("arst_left", sq.size(), 0);
    @(negedge aclk); rst = 1'b0;
    repeat (3) @(negedge aclk);
    chk("post_rst_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
